// File: rtl/ines_loader_if.sv
// ines_loader_if: download stream into the loader, ROM write port and cart status out of it
//   master : download source (drives dl_*, observes rom_*/status)
//   slave  : loader (consumes dl_*, drives rom_*/status)
interface ines_loader_if;
  logic        dl_start;
  logic        dl_wr;
  logic [7:0]  dl_data;
  logic        dl_done;
  logic        rom_wr;
  logic [21:0] rom_addr;
  logic [7:0]  rom_data;
  logic [31:0] flags;
  logic        hdr_valid;
  logic        load_done;
  logic        load_err;
  modport master (
    output dl_start, dl_wr, dl_data, dl_done,
    input  rom_wr, rom_addr, rom_data, flags, hdr_valid, load_done, load_err
  );
  modport slave (
    input  dl_start, dl_wr, dl_data, dl_done,
    output rom_wr, rom_addr, rom_data, flags, hdr_valid, load_done, load_err
  );
endinterface

// File: rtl/ines_loader.sv
// ines_loader: parses an iNES byte stream, writes PRG/CHR bytes to ROM and publishes cart flags
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of ines_loader_if (dl_* stream in; rom_wr/rom_addr/rom_data, flags, hdr_valid, load_done, load_err out)
module ines_loader (
  input logic          clk,
  input logic          reset_n,
  ines_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_TRAINER, S_PRG, S_CHR, S_DONE, S_ERROR} state_t;
  state_t      r_state, w_next;
  logic [21:0] r_off, w_off, w_off_inc, w_addr, w_prg_size, w_chr_size;
  logic [3:0]  r_hidx, w_hidx;
  logic [7:0]  r_prg16, r_chr8, r_b6, w_magic, w_mapper;
  logic [7:2]  r_b7;
  logic        r_tail_nz, w_tail_nz, w_active, w_cap, w_wr, w_hdr_ok;
  logic [2:0]  w_prg_lg, w_chr_lg;
  logic        r_rom_wr, r_hdr_valid, r_load_done, r_load_err;
  logic [21:0] r_rom_addr;
  logic [7:0]  r_rom_data;
  logic [31:0] r_flags;

  // ceil(log2(n)) for the legal size range 0..128
  function automatic logic [2:0] clog2_8(input logic [7:0] n);
    clog2_8 = 3'd0;
    for (int i = 0; i < 7; i++) if ((8'd1 << i) < n) clog2_8 = 3'(i + 1);
  endfunction

  assign w_off_inc  = r_off + 22'd1;
  assign w_prg_size = {r_prg16, 14'd0};
  assign w_chr_size = {1'b0, r_chr8, 13'd0};
  assign w_active   = r_state inside {S_HEADER, S_TRAINER, S_PRG, S_CHR};
  assign w_cap      = bus.dl_wr & ~bus.dl_start & ~bus.dl_done & (r_state == S_HEADER);
  assign w_magic    = (r_hidx == 4'd0) ? 8'h4E : (r_hidx == 4'd1) ? 8'h45 : (r_hidx == 4'd2) ? 8'h53 : 8'h1A;
  // byte 15 is still on the bus when the header completes, so fold it in here
  assign w_tail_nz  = r_tail_nz | (bus.dl_data != 8'd0);
  // garbage in bytes 12-15 of an old-style header invalidates the upper mapper nibble
  assign w_mapper   = (r_b7[3:2] != 2'b10 && w_tail_nz) ? {4'h0, r_b6[7:4]} : {r_b7[7:4], r_b6[7:4]};
  assign w_prg_lg   = clog2_8(r_prg16);
  assign w_chr_lg   = clog2_8(r_chr8);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_off    = r_off;
    w_hidx   = r_hidx;
    w_wr     = 1'b0;
    w_hdr_ok = 1'b0;
    w_addr   = r_off;
    if (bus.dl_start) begin
      w_next = S_HEADER;
      w_off  = '0;
      w_hidx = '0;
    end else if (bus.dl_done && w_active) begin
      w_next = S_ERROR;
    end else if (bus.dl_wr) begin
      case (r_state)
        S_HEADER: begin
          w_hidx = r_hidx + 4'd1;
          if (r_hidx < 4'd4 && bus.dl_data != w_magic) w_next = S_ERROR;
          else if (r_hidx == 4'd15) begin
            if (r_prg16 == 8'd0 || r_prg16 > 8'd128 || r_chr8 > 8'd128) w_next = S_ERROR;
            else begin
              w_hdr_ok = 1'b1;
              w_next   = r_b6[2] ? S_TRAINER : S_PRG;
              w_off    = '0;
            end
          end
        end
        S_TRAINER: begin
          w_off = w_off_inc;
          if (w_off_inc == 22'd512) begin
            w_next = S_PRG;
            w_off  = '0;
          end
        end
        S_PRG: begin
          w_wr  = 1'b1;
          w_off = w_off_inc;
          if (w_off_inc == w_prg_size) begin
            w_next = (r_chr8 != 8'd0) ? S_CHR : S_DONE;
            w_off  = '0;
          end
        end
        S_CHR: begin
          w_wr   = 1'b1;
          w_addr = 22'h200000 + r_off;
          w_off  = w_off_inc;
          if (w_off_inc == w_chr_size) begin
            w_next = S_DONE;
            w_off  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_off       <= '0;
      r_hidx      <= '0;
      r_prg16     <= '0;
      r_chr8      <= '0;
      r_b6        <= '0;
      r_b7        <= '0;
      r_tail_nz   <= 1'b0;
      r_flags     <= '0;
      r_hdr_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_rom_wr    <= 1'b0;
      r_rom_addr  <= '0;
      r_rom_data  <= '0;
    end else begin
      r_off  <= w_off;
      r_hidx <= w_hidx;
      if (w_cap && r_hidx == 4'd4) r_prg16 <= bus.dl_data;
      if (w_cap && r_hidx == 4'd5) r_chr8 <= bus.dl_data;
      if (w_cap && r_hidx == 4'd6) r_b6 <= bus.dl_data;
      if (w_cap && r_hidx == 4'd7) r_b7 <= bus.dl_data[7:2];
      r_tail_nz <= bus.dl_start ? 1'b0 : (w_cap && r_hidx >= 4'd12) ? w_tail_nz : r_tail_nz;
      if (w_hdr_ok) r_flags <= {14'd0, r_b6[1], r_b6[3], r_chr8 == 8'd0, r_b6[0], w_chr_lg, w_prg_lg, w_mapper};
      r_hdr_valid <= w_hdr_ok | (r_hdr_valid & ~bus.dl_start & (w_next != S_ERROR));
      r_load_done <= w_next == S_DONE;
      r_load_err  <= w_next == S_ERROR;
      r_rom_wr    <= w_wr;
      if (w_wr) begin
        r_rom_addr <= w_addr;
        r_rom_data <= bus.dl_data;
      end
    end
  end

  assign bus.rom_wr    = r_rom_wr;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_data  = r_rom_data;
  assign bus.flags     = r_flags;
  assign bus.hdr_valid = r_hdr_valid;
  assign bus.load_done = r_load_done;
  assign bus.load_err  = r_load_err;
endmodule
